// File: rtl/uctl_wakeup_signal_gen.sv
// USB remote-wakeup resume generator: waits for stable idle J,
// drives K for a programmed tick count, then releases the line.
module uctl_wakeup_signal_gen #(
   parameter int CNTR_WD     = 16,
   parameter int PRESCALE_WD = 8
) (
   input  logic                   aon_clk,
   input  logic                   aon_rst_n,
   input  logic                   sw_rst,
   input  logic                   wakeup_req,
   input  logic [CNTR_WD-1:0]     idle_time,
   input  logic [CNTR_WD-1:0]     drive_time,
   input  logic [PRESCALE_WD-1:0] tick_div,
   input  logic                   line_stable,
   input  logic                   line_idle,
   output logic                   drive_en,
   output logic                   drive_k,
   output logic                   busy,
   output logic                   done,
   output logic                   aborted
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_IDLE,
      DRIVE,
      RELEASE
   } state_t;

   state_t state_q, state_d;

   logic [CNTR_WD-1:0]     cnt_q, cnt_d;
   logic [CNTR_WD-1:0]     cnt_inc;
   logic [CNTR_WD-1:0]     drive_last;
   logic [PRESCALE_WD-1:0] pre_q, pre_d;
   logic                   req_q;
   logic                   tick;
   logic                   line_ok;
   logic                   start;
   logic                   done_d;
   logic                   aborted_d;

   assign tick       = (pre_q == tick_div);
   assign line_ok    = line_stable & line_idle;
   assign start      = wakeup_req & ~req_q;
   assign drive_last = (drive_time == '0) ? '0
                     : drive_time - CNTR_WD'(1);
   // saturate instead of wrapping when a compare is never met
   assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNTR_WD'(1);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pre_d     = '0;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      if (state_q != IDLE) begin
         pre_d = tick ? '0 : pre_q + PRESCALE_WD'(1);
      end
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = WAIT_IDLE;
               cnt_d   = '0;
            end
         end
         WAIT_IDLE: begin
            if (!wakeup_req) begin
               state_d   = IDLE;
               cnt_d     = '0;
               aborted_d = 1'b1;
            end else if (!line_ok) begin
               cnt_d = '0;
               pre_d = '0;
            end else if (cnt_q == idle_time) begin
               state_d = DRIVE;
               cnt_d   = '0;
            end else if (tick) begin
               cnt_d = cnt_inc;
            end
         end
         DRIVE: begin
            if (tick) begin
               if (cnt_q == drive_last) begin
                  state_d = RELEASE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         RELEASE: begin
            if (cnt_q[0]) begin
               state_d = IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = CNTR_WD'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      if (state_d != state_q) begin
         pre_d = '0;
      end
   end

   always_ff @(posedge aon_clk or negedge aon_rst_n) begin
      if (!aon_rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         pre_q    <= '0;
         req_q    <= 1'b0;
         drive_en <= 1'b0;
         drive_k  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         aborted  <= 1'b0;
      end else if (sw_rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         pre_q    <= '0;
         req_q    <= 1'b0;
         drive_en <= 1'b0;
         drive_k  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         aborted  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pre_q    <= pre_d;
         req_q    <= wakeup_req;
         drive_en <= (state_d == DRIVE);
         drive_k  <= (state_d == DRIVE);
         busy     <= (state_d != IDLE);
         done     <= done_d;
         aborted  <= aborted_d;
      end
   end

endmodule

// File: tb/tb_uctl_wakeup_signal_gen.sv
// Bench for uctl_wakeup_signal_gen: table of timing vectors plus
// hand sequences for line restart, abort, and resets.
module tb_uctl_wakeup_signal_gen;

   logic        aon_clk;
   logic        aon_rst_n;
   logic        sw_rst;
   logic        wakeup_req;
   logic [15:0] idle_time;
   logic [15:0] drive_time;
   logic [7:0]  tick_div;
   logic        line_stable;
   logic        line_idle;
   logic        drive_en;
   logic        drive_k;
   logic        busy;
   logic        done;
   logic        aborted;

   uctl_wakeup_signal_gen #(
      .CNTR_WD    (16),
      .PRESCALE_WD(8)
   ) dut (
      .aon_clk    (aon_clk),
      .aon_rst_n  (aon_rst_n),
      .sw_rst     (sw_rst),
      .wakeup_req (wakeup_req),
      .idle_time  (idle_time),
      .drive_time (drive_time),
      .tick_div   (tick_div),
      .line_stable(line_stable),
      .line_idle  (line_idle),
      .drive_en   (drive_en),
      .drive_k    (drive_k),
      .busy       (busy),
      .done       (done),
      .aborted    (aborted)
   );

   initial aon_clk = 1'b0;
   always #5 aon_clk = ~aon_clk;

   // {busy, drive_en, drive_k, done, aborted}
   localparam logic [4:0] Z   = 5'b00000;
   localparam logic [4:0] B   = 5'b10000;
   localparam logic [4:0] DRV = 5'b11100;
   localparam logic [4:0] DN  = 5'b00010;
   localparam logic [4:0] AB  = 5'b00001;

   typedef struct {
      int div;
      int idle;
      int dt;
      int w;
      int d;
   } vec_t;

   vec_t       tbl[5];
   logic [4:0] sb_q[$];
   int         errors;
   int         checks;
   int         cyc;

   function automatic logic [4:0] outs();
      return {busy, drive_en, drive_k, done, aborted};
   endfunction

   task automatic check(input string name, input logic [4:0] act,
                        input logic [4:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc%0d: got %b want %b", name, cyc, act, exp);
      end
   endtask

   // expectation queued with the stimulus, compared after the edge
   task automatic step(input string name, input logic [4:0] exp);
      logic [4:0] e;
      sb_q.push_back(exp);
      @(posedge aon_clk);
      #1;
      cyc++;
      e = sb_q.pop_front();
      check(name, outs(), e);
   endtask

   task automatic setup(input int div, input int idle, input int dt);
      tick_div   = 8'(div);
      idle_time  = 16'(idle);
      drive_time = 16'(dt);
   endtask

   task automatic run_row(input vec_t v, input int idx);
      string nm;
      nm = $sformatf("row%0d", idx);
      setup(v.div, v.idle, v.dt);
      wakeup_req = 1'b1;
      for (int i = 0; i < v.w; i++) step({nm, "_wait"}, B);
      for (int i = 0; i < v.d; i++) step({nm, "_drive"}, DRV);
      for (int i = 0; i < 2; i++) step({nm, "_release"}, B);
      step({nm, "_done"}, DN);
      for (int i = 0; i < 3; i++) step({nm, "_held"}, Z);
      wakeup_req = 1'b0;
      step({nm, "_drop"}, Z);
   endtask

   initial begin
      errors      = 0;
      checks      = 0;
      cyc         = 0;
      aon_rst_n   = 1'b0;
      sw_rst      = 1'b0;
      wakeup_req  = 1'b0;
      line_stable = 1'b1;
      line_idle   = 1'b1;
      setup(0, 3, 5);

      tbl[0] = '{div: 0, idle: 3, dt: 5, w: 4, d: 5};
      tbl[1] = '{div: 3, idle: 1, dt: 2, w: 5, d: 8};
      tbl[2] = '{div: 0, idle: 0, dt: 0, w: 1, d: 1};
      tbl[3] = '{div: 1, idle: 2, dt: 3, w: 5, d: 6};
      tbl[4] = '{div: 2, idle: 0, dt: 1, w: 1, d: 3};

      #12;
      check("reset_outs", outs(), Z);
      @(negedge aon_clk);
      aon_rst_n = 1'b1;
      step("post_reset", Z);

      for (int i = 0; i < 5; i++) run_row(tbl[i], i);

      // line drops at cnt=2: window restarts, 4 fresh ok ticks needed
      setup(0, 4, 1);
      wakeup_req = 1'b1;
      step("rst_win_w0", B);
      step("rst_win_w1", B);
      step("rst_win_w2", B);
      line_idle = 1'b0;
      step("rst_win_drop", B);
      line_idle = 1'b1;
      for (int i = 0; i < 4; i++) step("rst_win_w", B);
      step("rst_win_drive", DRV);
      step("rst_win_rel0", B);
      step("rst_win_rel1", B);
      step("rst_win_done", DN);
      wakeup_req = 1'b0;
      step("rst_win_idle", Z);

      // request withdrawn while waiting
      setup(0, 5, 2);
      wakeup_req = 1'b1;
      step("abort_w0", B);
      step("abort_w1", B);
      wakeup_req = 1'b0;
      step("abort_pulse", AB);
      step("abort_after", Z);

      // abort beats a simultaneous DRIVE entry
      setup(0, 0, 2);
      wakeup_req = 1'b1;
      step("abort0_w0", B);
      wakeup_req = 1'b0;
      step("abort0_pulse", AB);
      step("abort0_after", Z);

      // sw_rst mid-DRIVE
      setup(0, 0, 5);
      wakeup_req = 1'b1;
      step("swrst_w0", B);
      step("swrst_d0", DRV);
      step("swrst_d1", DRV);
      sw_rst     = 1'b1;
      wakeup_req = 1'b0;
      step("swrst_clr", Z);
      sw_rst = 1'b0;
      step("swrst_after0", Z);
      step("swrst_after1", Z);

      // async reset mid-DRIVE
      wakeup_req = 1'b1;
      step("arst_w0", B);
      step("arst_d0", DRV);
      step("arst_d1", DRV);
      #2;
      aon_rst_n = 1'b0;
      #1;
      check("arst_immediate", outs(), Z);
      wakeup_req = 1'b0;
      @(negedge aon_clk);
      aon_rst_n = 1'b1;
      step("arst_after", Z);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
